// File: rtl/row_mac_pkg.sv
// Shared definitions for the row multiply-accumulate engine: the row count,
// the accumulator width rule and the controller state encoding.
// Optional build macro: ROW_MAC_SIGNED_EN (two's complement operands).
package row_mac_pkg;

   // Number of A elements per row, B rows and B columns.
   localparam int ROWS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A 2N-bit product summed 8 times needs 3 extra bits to never overflow.
   function automatic int acc_width(input int n);
      return 2 * n + 3;
   endfunction

endpackage

// File: rtl/row_mac_lane.sv
// One output column of the row engine: a single N x N multiplier feeding an
// accumulator with synchronous clear and enable.
// Optional build macro: ROW_MAC_SIGNED_EN (operands are two's complement).
module row_mac_lane
   import row_mac_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic [N-1:0]            a,
   input  logic [N-1:0]            b,
   output logic [acc_width(N)-1:0] sum
);

   localparam int ACC_W = acc_width(N);

   logic [2*N-1:0]   prod_w;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_reg;

`ifdef ROW_MAC_SIGNED_EN
   // Sign-extend both operands to 2N bits so the product's low 2N bits are exact.
   assign prod_w   = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
   assign prod_ext = {{(ACC_W - 2*N){prod_w[2*N-1]}}, prod_w};
`else
   // Zero-extend so the multiply is carried out at full 2N-bit precision.
   assign prod_w   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
   assign prod_ext = {{(ACC_W - 2*N){1'b0}}, prod_w};
`endif

   // Running total including the current term; the controller captures this
   // on the last accumulation edge so no extra cycle is needed for the result.
   assign sum = acc_reg + prod_ext;

   // Accumulator register: clear wins over enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (clr) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= sum;
      end
   end

endmodule

// File: rtl/row_mac_engine.sv
// Row x matrix multiply-accumulate engine: y_j = sum_k a_k * b_kj for an
// 8-element row and an 8x8 matrix, one k per clock across 8 parallel lanes.
// Optional build macro: ROW_MAC_SIGNED_EN (two's complement operands).
module row_mac_engine
   import row_mac_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ROWS*N-1:0]              a_row,
   input  logic [ROWS*ROWS*N-1:0]         b_mat,
   output logic [ROWS*acc_width(N)-1:0]   y_row,
   output logic                           done,
   output logic                           busy
);

   localparam int ACC_W = acc_width(N);

   state_t           state_reg;
   logic [2:0]       k_reg;
   logic [N-1:0]     a_lat_reg [ROWS];
   logic [ROWS*ACC_W-1:0] y_row_reg;
   logic             done_reg;
   logic             busy_reg;

   logic [N-1:0]     b_arr [ROWS][ROWS];
   logic [ACC_W-1:0] sums  [ROWS];
   logic             lane_clr;
   logic             lane_en;

   // B is unpacked into a 2-D array so row k can be selected by the counter.
   genvar gi, gk;
   generate
      for (gk = 0; gk < ROWS; gk++) begin : g_brow
         for (gi = 0; gi < ROWS; gi++) begin : g_bcol
            assign b_arr[gk][gi] = b_mat[(ROWS*gk + gi)*N +: N];
         end
      end
   endgenerate

   // Lanes clear on the start edge and accumulate on every ACC edge that is
   // not an abort.
   assign lane_clr = (state_reg == IDLE) && start;
   assign lane_en  = (state_reg == ACC) && start;

   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_lane
         row_mac_lane #(
            .N (N)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (lane_en),
            .a     (a_lat_reg[k_reg]),
            .b     (b_arr[k_reg][gi]),
            .sum   (sums[gi])
         );
      end
   endgenerate

   // Controller: latches A, steps k through the row and publishes the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         y_row_reg <= '0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         for (int i = 0; i < ROWS; i++) begin
            a_lat_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < ROWS; i++) begin
                     a_lat_reg[i] <= a_row[i*N +: N];
                  end
                  k_reg     <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ACC;
               end
            end
            ACC: begin
               if (!start) begin
                  // Abort: previous result and done stay as they were.
                  k_reg     <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (k_reg == 3'(ROWS - 1)) begin
                  for (int j = 0; j < ROWS; j++) begin
                     y_row_reg[j*ACC_W +: ACC_W] <= sums[j];
                  end
                  k_reg     <= '0;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  k_reg <= k_reg + 3'd1;
               end
            end
            DONE: begin
               // Holding start high keeps the result; only a low start re-arms.
               if (!start) begin
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               k_reg     <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign y_row = y_row_reg;
   assign done  = done_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_row_mac_engine.sv
// Self-checking bench for row_mac_engine: directed corner rows plus random rows
// compared against a plain-arithmetic dot-product model.
// Honors ROW_MAC_SIGNED_EN to select the operand interpretation of the model.
module tb_row_mac_engine;

   localparam int N     = 8;
   localparam int R     = 8;
   localparam int ACC_W = 2 * N + 3;

   logic                    clk;
   logic                    rst_n;
   logic                    start;
   logic [R*N-1:0]          a_row;
   logic [R*R*N-1:0]        b_mat;
   logic [R*ACC_W-1:0]      y_row;
   logic                    done;
   logic                    busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int row_count    = 0;

   int     am [R];
   int     bm [R][R];
   longint exp_y [R];

   row_mac_engine #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a_row (a_row),
      .b_mat (b_mat),
      .y_row (y_row),
      .done  (done),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint expv);
      tests_run++;
      if (obs !== expv) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Operand value as the engine is meant to interpret the raw bits.
   function automatic longint opval(input int raw);
`ifdef ROW_MAC_SIGNED_EN
      return (raw >= (1 << (N - 1))) ? longint'(raw - (1 << N)) : longint'(raw);
`else
      return longint'(raw);
`endif
   endfunction

   // Output element j read back as a number in the same interpretation.
   function automatic longint yval(input int j);
      logic [ACC_W-1:0] e;
      longint v;
      e = y_row[j*ACC_W +: ACC_W];
      v = longint'(e);
`ifdef ROW_MAC_SIGNED_EN
      if (e[ACC_W-1]) v = v - (longint'(1) << ACC_W);
`endif
      return v;
   endfunction

   // Drive the ports from the model arrays and compute the expected row.
   task automatic load_inputs();
      for (int k = 0; k < R; k++) begin
         a_row[k*N +: N] = N'(am[k]);
         for (int j = 0; j < R; j++) b_mat[(R*k + j)*N +: N] = N'(bm[k][j]);
      end
      for (int j = 0; j < R; j++) begin
         exp_y[j] = 0;
         for (int k = 0; k < R; k++) exp_y[j] += opval(am[k]) * opval(bm[k][j]);
      end
   endtask

   task automatic randomize_operands();
      for (int k = 0; k < R; k++) begin
         am[k] = int'($urandom_range(0, (1 << N) - 1));
         for (int j = 0; j < R; j++) bm[k][j] = int'($urandom_range(0, (1 << N) - 1));
      end
   endtask

   // One full computation; a_row is scrambled after the latch edge, start is
   // optionally held in DONE for `hold` cycles and then dropped if `drop`.
   task automatic do_row(input string tag, input int hold, input bit drop);
      int cycles;
      int bcnt;
      load_inputs();
      start  = 1'b1;
      cycles = 0;
      bcnt   = 0;
      do begin
         tick();
         cycles++;
         if (busy) bcnt++;
         a_row = {$urandom, $urandom};
      end while (!done && cycles < 30);
      check({tag, "_latency"}, cycles, 9);
      check({tag, "_busy_cycles"}, bcnt, 8);
      for (int j = 0; j < R; j++) check($sformatf("%s_y%0d", tag, j), yval(j), exp_y[j]);
      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, "_hold_done"}, done, 1);
         check({tag, "_hold_busy"}, busy, 0);
      end
      if (drop) begin
         start = 1'b0;
         tick();
         check({tag, "_drop_done"}, done, 0);
         check({tag, "_drop_y0_kept"}, yval(0), exp_y[0]);
      end
      row_count++;
      $display("[TB] row %0d (%s) y0=%0d y7=%0d", row_count, tag, yval(0), yval(7));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
      for (int j = 0; j < R; j++) check($sformatf("%s_y%0d", tag, j), yval(j), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_row = '0;
      b_mat = '0;
      tick();
      tick();
      check_cleared("reset");
      rst_n = 1'b1;
      tick();

      // a = all ones, B = identity.
      for (int k = 0; k < R; k++) begin
         am[k] = 1;
         for (int j = 0; j < R; j++) bm[k][j] = (k == j) ? 1 : 0;
      end
      do_row("ident", 2, 1'b1);
      for (int j = 0; j < R; j++) check($sformatf("ident_const_y%0d", j), yval(j), 1);

      // Largest bit patterns everywhere.
      for (int k = 0; k < R; k++) begin
         am[k] = (1 << N) - 1;
         for (int j = 0; j < R; j++) bm[k][j] = (1 << N) - 1;
      end
      do_row("max", 0, 1'b1);
`ifdef ROW_MAC_SIGNED_EN
      check("max_const", yval(3), 8);
      // Most negative operands everywhere.
      for (int k = 0; k < R; k++) begin
         am[k] = 1 << (N - 1);
         for (int j = 0; j < R; j++) bm[k][j] = 1 << (N - 1);
      end
      do_row("minneg", 0, 1'b1);
      check("minneg_const", yval(5), 131072);
      // a_k = k-4, b = 1 everywhere.
      for (int k = 0; k < R; k++) begin
         am[k] = (k - 4) & ((1 << N) - 1);
         for (int j = 0; j < R; j++) bm[k][j] = 1;
      end
      do_row("ramp", 0, 1'b1);
      check("ramp_const", yval(2), -4);
`else
      check("max_const", yval(3), 520200);
`endif

      // Abort on the 4th ACC edge: nothing published.
      begin
         longint prev_y [R];
         for (int j = 0; j < R; j++) prev_y[j] = yval(j);
         randomize_operands();
         load_inputs();
         start = 1'b1;
         for (int i = 0; i < 4; i++) tick();
         start = 1'b0;
         tick();
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         for (int j = 0; j < R; j++) check($sformatf("abort_y%0d_kept", j), yval(j), prev_y[j]);
         tick();
         check("abort_idle_done", done, 0);
         randomize_operands();
         do_row("after_abort", 0, 1'b1);
      end

      // Reset in the middle of accumulation, with start held through reset.
      randomize_operands();
      load_inputs();
      start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      tick();
      check_cleared("rst_acc");
      tick();
      check("rst_acc_start_ignored", busy, 0);
      rst_n = 1'b1;
      randomize_operands();
      do_row("rst_release", 0, 1'b1);

      // Reset while sitting in DONE.
      randomize_operands();
      do_row("pre_rst_done", 3, 1'b0);
      rst_n = 1'b0;
      tick();
      check_cleared("rst_done");
      start = 1'b0;
      rst_n = 1'b1;
      tick();

      // Back-to-back random rows, start low for exactly one cycle between.
      for (int r = 0; r < 8; r++) begin
         randomize_operands();
         do_row($sformatf("rand%0d", r), r % 3, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/row_mac_engine.md
ROW_MAC_ENGINE -- requirements
Module: row_mac_engine

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits of every A and B element.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level request from the row controller; held high until done is seen.
REQ-005 SHALL have port a_row  input  8*N  A row vector, element k at bits [k*N +: N].
REQ-006 SHALL have port b_mat  input  64*N  B matrix, element (k,j) at bits [(8*k+j)*N +: N]; caller holds it stable while busy.
REQ-007 SHALL have port y_row  output  8*(2N+3)  result row, element j at bits [j*(2N+3) +: 2N+3].
REQ-008 SHALL have port done  output  1  result valid; held while start stays high.
REQ-009 SHALL have port busy  output  1  high in state ACC.

Function
REQ-010 SHALL compute y_j = sum over k=0..7 of a_k * b_kj for j=0..7, full precision, result width 2N+3, no truncation or saturation.
REQ-011 SHALL implement states IDLE, ACC, DONE; the reset state is IDLE.
REQ-012 In IDLE with start=1, SHALL on that edge latch a_row, clear all 8 accumulators, set k=0 and go to ACC.
REQ-013 In ACC, each edge SHALL add a_k*b_kj into accumulator j for all 8 j in parallel and then increment k.
REQ-014 On the edge that processes k=7, SHALL load y_row from the final sums, set done=1 and go to DONE.
REQ-015 done SHALL first be high after exactly 9 rising edges, counted from and including the edge that samples start high in IDLE.
REQ-016 In ACC with start=0, SHALL abort to IDLE; done and y_row SHALL remain unchanged.
REQ-017 In DONE with start=1, SHALL hold state, done=1 and y_row.
REQ-018 In DONE with start=0, SHALL go to IDLE and clear done; y_row SHALL hold its last value.
REQ-019 A new computation SHALL require start low for at least one cycle after DONE; start held high never retriggers.
REQ-020 Changes on a_row after the latch edge SHALL NOT affect the result.
REQ-021 b_mat SHALL be sampled on each ACC edge, one row k per edge.

Reset
REQ-022 With rst_n=0 at a rising edge, SHALL set state=IDLE, k=0, accumulators=0, y_row=0, done=0 and busy=0.
REQ-023 Reset SHALL take priority over every other event, including mid-ACC and in DONE; start is ignored while rst_n=0.
REQ-024 After rst_n is released, start already high SHALL begin a computation on the first edge.

Configuration
REQ-025 With macro ROW_MAC_SIGNED_EN defined, SHALL treat a and b elements as two's complement, with sign-extended products and accumulation.
REQ-026 Without ROW_MAC_SIGNED_EN, SHALL treat all operands as unsigned.
REQ-027 Timing and handshake SHALL be identical in both builds.

Structure
REQ-028 Package row_mac_pkg SHALL hold ROWS=8, the accumulator-width function (2N+3) and the state enum IDLE/ACC/DONE.
REQ-029 SHALL instantiate sub-module row_mac_lane 8 times; each lane holds one multiplier and one accumulator with clear and enable controls.
REQ-030 The k counter and the state machine SHALL reside in row_mac_engine only.

Verification
REQ-031 Unsigned, N=8, a=all 1, B=identity, start held -> done at edge 9, every y_j=1, busy high for 8 cycles.
REQ-032 Unsigned, a=all 255, B=all 255 -> every y_j=520200 (0x7F008), no overflow in 19 bits.
REQ-033 ROW_MAC_SIGNED_EN, a=all -128, B=all -128 -> every y_j=131072; a_k=k-4, b_kj=1 -> every y_j=-4.
REQ-034 start dropped on the 4th ACC edge -> IDLE next cycle, done stays 0, y_row keeps its prior value; next start gives the correct result.
REQ-035 rst_n=0 mid-ACC and in DONE -> next cycle y_row=0, done=0, state IDLE.
REQ-036 Eight back-to-back rows, start dropped 1 cycle after each done -> all 64 outputs match the reference model; start held high in DONE does not retrigger.
